// File: rtl/clint_mhart_pkg.sv
// Shared definitions for the core-local interruptor.
// Contents: register map offsets and strides, Wishbone FSM state type, and a
// byte-lane merge helper used by every writable register.
package clint_mhart_pkg;

    localparam logic [15:0] ClintMsipOff        = 16'h0000;
    localparam logic [15:0] ClintMtimecmpOff    = 16'h4000;
    localparam logic [15:0] ClintMtimeOff       = 16'hBFF8;
    localparam int unsigned ClintMsipStride     = 4;
    localparam int unsigned ClintMtimecmpStride = 8;

    typedef enum logic [0:0] {StIdle, StAck} wb_state_e;

    // Replace the bytes of old_val selected by sel with the matching bytes of new_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_cmp.sv
// One hart's 64-bit mtimecmp register and timer-pending comparator.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   we_lo_i/hi_i   write strobe for the low/high word of mtimecmp
//   sel_i, wdat_i  byte enables and write data
//   mtime_i        current mtime
//   mtimecmp_o     current mtimecmp (for bus read-back)
//   mtip_o         registered (mtime >= mtimecmp)
module clint_cmp
    import clint_mhart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdat_i,
    input  logic [63:0] mtime_i,
    output logic [63:0] mtimecmp_o,
    output logic        mtip_o
);

    logic [63:0] cmp_q, cmp_d;
    logic        mtip_q;

    always_comb begin
        cmp_d = cmp_q;
        if (we_lo_i) cmp_d[31:0]  = merge_bytes(cmp_q[31:0], wdat_i, sel_i);
        if (we_hi_i) cmp_d[63:32] = merge_bytes(cmp_q[63:32], wdat_i, sel_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmp_q  <= '1;
            mtip_q <= 1'b0;
        end else begin
            cmp_q  <= cmp_d;
            // Compares current register values: one cycle of latency after any change.
            mtip_q <= (mtime_i >= cmp_q);
        end
    end

    assign mtimecmp_o = cmp_q;
    assign mtip_o     = mtip_q;

endmodule

// File: rtl/clint_mhart.sv
// Core-local interruptor, Wishbone slave. Holds mtime with a prescaler, one msip
// bit and one mtimecmp per hart, and drives registered mtip/msip lines.
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   wb_adr_i/dat_i/sel_i/we_i/stb_i/cyc_i   Wishbone slave inputs
//   wb_dat_o, wb_ack_o   registered read data and acknowledge
//   mtip_o, msip_o       per-hart timer / software pending, registered
module clint_mhart
    import clint_mhart_pkg::*;
#(
    parameter int unsigned NHART = 1,
    parameter logic [31:0] BASE  = 32'h0200_0000,
    parameter int unsigned DIV   = 1,
    parameter int unsigned DIVW  = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic [NHART-1:0] mtip_o,
    output logic [NHART-1:0] msip_o
);

    localparam logic [15:0]     MsipSpan = 16'(NHART * ClintMsipStride);
    localparam logic [15:0]     CmpSpan  = 16'(NHART * ClintMtimecmpStride);
    localparam logic [DIVW-1:0] DivLast  = DIVW'(DIV - 1);

    wb_state_e        state_q, state_d;
    logic             access, wr;
    logic             in_blk, msip_hit, cmp_hit, mtime_hit;
    logic [15:0]      off, msip_off, cmp_off;
    logic [DIVW-1:0]  presc_q, presc_d;
    logic             tick;
    logic [63:0]      mtime_q, mtime_d;
    logic [NHART-1:0] msip_q, msip_d, msip_out_q;
    logic [NHART-1:0] cmp_we_lo, cmp_we_hi;
    logic [63:0]      cmp_val [NHART];
    logic [31:0]      rdata, dat_q;
    logic             unused_adr;

    // Address decode; the block occupies the 64 KiB window selected by BASE[31:16].
    assign unused_adr = ^wb_adr_i[1:0];
    assign in_blk     = (wb_adr_i[31:16] == BASE[31:16]);
    assign off        = {wb_adr_i[15:2], 2'b00};
    assign msip_off   = off - ClintMsipOff;
    assign cmp_off    = off - ClintMtimecmpOff;
    // Unsigned wrap of the subtraction makes offsets below each region fail the span test.
    assign msip_hit   = in_blk && (msip_off < MsipSpan);
    assign cmp_hit    = in_blk && (cmp_off < CmpSpan);
    assign mtime_hit  = in_blk && (off[15:3] == ClintMtimeOff[15:3]);

    assign access = wb_cyc_i && wb_stb_i && (state_q == StIdle);
    assign wr     = access && wb_we_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (wb_cyc_i && wb_stb_i) state_d = StAck;
            StAck:  state_d = StIdle;
        endcase
    end

    // Prescaler and mtime; a bus write to one half overrides the increment for that
    // half only, so no carry crosses between halves on that edge.
    always_comb begin
        tick    = (presc_q == DivLast);
        presc_d = tick ? '0 : presc_q + DIVW'(1);
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr && mtime_hit) begin
            if (off[2]) begin
                mtime_d[63:32] = merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i);
            end else begin
                mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel_i)};
            end
        end
    end

    always_comb begin
        msip_d    = msip_q;
        cmp_we_lo = '0;
        cmp_we_hi = '0;
        for (int h = 0; h < NHART; h++) begin
            if (wr && msip_hit && (msip_off[5:2] == 4'(h)) && wb_sel_i[0]) begin
                msip_d[h] = wb_dat_i[0];
            end
            if (wr && cmp_hit && (cmp_off[6:3] == 4'(h))) begin
                cmp_we_lo[h] = !off[2];
                cmp_we_hi[h] = off[2];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int h = 0; h < NHART; h++) begin
            if (msip_hit && (msip_off[5:2] == 4'(h))) rdata = {31'd0, msip_q[h]};
            if (cmp_hit && (cmp_off[6:3] == 4'(h))) begin
                rdata = off[2] ? cmp_val[h][63:32] : cmp_val[h][31:0];
            end
        end
        if (mtime_hit) rdata = off[2] ? mtime_q[63:32] : mtime_q[31:0];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            mtime_q    <= '0;
            msip_q     <= '0;
            msip_out_q <= '0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            msip_q     <= msip_d;
            msip_out_q <= msip_q;
            if (access && !wb_we_i) dat_q <= rdata;
        end
    end

    for (genvar h = 0; h < NHART; h++) begin : g_hart
        clint_cmp u_cmp (
            .clk_i      (wb_clk_i),
            .rst_i      (wb_rst_i),
            .we_lo_i    (cmp_we_lo[h]),
            .we_hi_i    (cmp_we_hi[h]),
            .sel_i      (wb_sel_i),
            .wdat_i     (wb_dat_i),
            .mtime_i    (mtime_q),
            .mtimecmp_o (cmp_val[h]),
            .mtip_o     (mtip_o[h])
        );
    end

    assign wb_ack_o = (state_q == StAck);
    assign wb_dat_o = dat_q;
    assign msip_o   = msip_out_q;

endmodule

// File: tb/tb_clint_mhart.sv
// Directed bench for clint_mhart: one instance with DIV=1 and one with DIV=4,
// both NHART=2, sharing all bus inputs except wb_cyc_i.
module tb_clint_mhart;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [31:0] adr  = '0;
    logic [31:0] dat  = '0;
    logic [3:0]  sel  = '0;
    logic        we   = 1'b0;
    logic        stb  = 1'b0;
    logic        cyc1 = 1'b0;
    logic        cyc4 = 1'b0;

    logic [31:0] dat1, dat4;
    logic        ack1, ack4;
    logic [1:0]  mtip1, msip1, mtip4, msip4;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] r0, r1;

    always #5 clk = ~clk;

    clint_mhart #(.NHART(2), .BASE(32'h0200_0000), .DIV(1), .DIVW(8)) u_d1 (
        .wb_clk_i (clk),  .wb_rst_i (rst),  .wb_adr_i (adr), .wb_dat_i (dat),
        .wb_sel_i (sel),  .wb_we_i  (we),   .wb_stb_i (stb), .wb_cyc_i (cyc1),
        .wb_dat_o (dat1), .wb_ack_o (ack1), .mtip_o   (mtip1), .msip_o (msip1)
    );

    clint_mhart #(.NHART(2), .BASE(32'h0200_0000), .DIV(4), .DIVW(8)) u_d4 (
        .wb_clk_i (clk),  .wb_rst_i (rst),  .wb_adr_i (adr), .wb_dat_i (dat),
        .wb_sel_i (sel),  .wb_we_i  (we),   .wb_stb_i (stb), .wb_cyc_i (cyc4),
        .wb_dat_o (dat4), .wb_ack_o (ack4), .mtip_o   (mtip4), .msip_o (msip4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; access lands on the next edge, then one idle edge.
    task automatic xfer(input bit d4, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s, output logic [31:0] q);
        adr = a; dat = wd; sel = s; we = w; stb = 1'b1;
        if (d4) cyc4 = 1'b1; else cyc1 = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("ack %h", a), 64'(d4 ? ack4 : ack1), 64'd1);
        q = d4 ? dat4 : dat1;
        cyc1 = 1'b0; cyc4 = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("ack_drop %h", a), 64'(d4 ? ack4 : ack1), 64'd0);
    endtask

    task automatic rd(input bit d4, input logic [31:0] a, output logic [31:0] q);
        xfer(d4, 1'b0, a, 32'd0, 4'hF, q);
    endtask

    task automatic wr(input bit d4, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] unused_q;
        xfer(d4, 1'b1, a, d, s, unused_q);
    endtask

    initial begin
        // Reset state
        idle(3);
        rst = 1'b0;
        chk("rst_ack", 64'(ack1), 64'd0);
        chk("rst_dat", 64'(dat1), 64'd0);
        chk("rst_mtip", 64'(mtip1), 64'd0);
        chk("rst_msip", 64'(msip1), 64'd0);
        chk("rst_mtip4", 64'(mtip4), 64'd0);
        rd(0, 32'h0200_4000, r0);
        chk("rst_cmp0_lo", 64'(r0), 64'hFFFF_FFFF);
        rd(0, 32'h0200_4004, r0);
        chk("rst_cmp0_hi", 64'(r0), 64'hFFFF_FFFF);
        // mtime counts from the first edge after release: 4 increments before this access
        rd(0, 32'h0200_BFF8, r0);
        chk("rst_mtime", 64'(r0), 64'd4);
        rd(0, 32'h0200_BFF8, r0);
        chk("mtime_step", 64'(r0), 64'd6);

        // Timer compare on hart 1
        wr(0, 32'h0200_4008, 32'd100, 4'hF);
        wr(0, 32'h0200_400C, 32'd0, 4'hF);
        rd(0, 32'h0200_BFF8, r0);
        chk("t2_mtime", 64'(r0), 64'd12);
        // Edge k after that read samples mtime 12+k
        for (int k = 2; k <= 95; k++) begin
            @(posedge clk); #1;
            chk($sformatf("t2_mtip1 k=%0d", k), 64'(mtip1[1]), 64'((12 + k) >= 100));
            chk($sformatf("t2_mtip0 k=%0d", k), 64'(mtip1[0]), 64'd0);
        end
        rd(0, 32'h0200_4008, r0);
        chk("t2_cmp1_lo", 64'(r0), 64'd100);

        // Prescaler DIV=4: 40 clocks between accesses
        rd(1, 32'h0200_BFF8, r0);
        idle(38);
        rd(1, 32'h0200_BFF8, r1);
        chk("t3_delta", 64'(r1 - r0), 64'd10);
        rd(1, 32'h0200_BFFC, r1);
        chk("t3_hi", 64'(r1), 64'd0);

        // mtime hi write with partial lanes, then carry from increment
        wr(0, 32'h0200_BFF8, 32'hFFFF_FFF0, 4'hF);
        wr(0, 32'h0200_BFFC, 32'hABCD_0001, 4'b0011);
        rd(0, 32'h0200_BFF8, r0);
        chk("t4_lo", 64'(r0), 64'hFFFF_FFF3);
        rd(0, 32'h0200_BFFC, r0);
        chk("t4_hi", 64'(r0), 64'd1);
        idle(20);
        rd(0, 32'h0200_BFFC, r0);
        chk("t4_hi_carry", 64'(r0), 64'd2);
        rd(0, 32'h0200_BFF8, r0);
        chk("t4_lo_wrap", 64'(r0), 64'h0000_000D);
        chk("t4_mtip", 64'(mtip1), 64'b10);

        // Software interrupts
        wr(0, 32'h0200_0004, 32'd1, 4'hF);
        chk("t5_msip_set", 64'(msip1), 64'b10);
        rd(0, 32'h0200_0004, r0);
        chk("t5_rd1", 64'(r0), 64'd1);
        rd(0, 32'h0200_0000, r0);
        chk("t5_rd0", 64'(r0), 64'd0);
        wr(0, 32'h0200_0000, 32'hFFFF_FFFF, 4'hF);
        chk("t5_msip_both", 64'(msip1), 64'b11);
        rd(0, 32'h0200_0000, r0);
        chk("t5_rd0_bit0", 64'(r0), 64'd1);
        wr(0, 32'h0200_0000, 32'd0, 4'b1110);
        chk("t5_sel_ignored", 64'(msip1), 64'b11);
        wr(0, 32'h0200_0000, 32'd0, 4'hF);
        wr(0, 32'h0200_0008, 32'd1, 4'hF);
        rd(0, 32'h0200_0008, r0);
        chk("t5_unmapped_hart", 64'(r0), 64'd0);
        chk("t5_msip_mid", 64'(msip1), 64'b10);
        wr(0, 32'h0200_0004, 32'd0, 4'hF);
        chk("t5_msip_clr", 64'(msip1), 64'b00);

        // Held strobe: ack toggles, unmapped read returns 0
        rd(0, 32'h0200_4000, r0);
        adr = 32'h0200_8000; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc1 = 1'b1;
        chk("t6_ack0", 64'(ack1), 64'd0);
        chk("t6_dat_hold", 64'(dat1), 64'hFFFF_FFFF);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("t6_ack i=%0d", i), 64'(ack1), 64'(i % 2));
            if (i % 2 == 1) chk($sformatf("t6_dat i=%0d", i), 64'(dat1), 64'd0);
        end
        cyc1 = 1'b0; stb = 1'b0;
        idle(1);

        // Reset in the middle of a transfer
        wr(0, 32'h0200_0004, 32'd1, 4'hF);
        adr = 32'h0200_BFF8; we = 1'b0; stb = 1'b1; cyc1 = 1'b1;
        @(posedge clk); #1;
        chk("t7_ack_before", 64'(ack1), 64'd1);
        rst = 1'b1;
        #1;
        chk("t7_ack_rst", 64'(ack1), 64'd0);
        chk("t7_dat_rst", 64'(dat1), 64'd0);
        chk("t7_msip_rst", 64'(msip1), 64'd0);
        chk("t7_mtip_rst", 64'(mtip1), 64'd0);
        cyc1 = 1'b0; stb = 1'b0;
        #2;
        rst = 1'b0;
        idle(1);
        rd(0, 32'h0200_400C, r0);
        chk("t7_cmp1_hi", 64'(r0), 64'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
